// File: rtl/tea_encrypt.sv
// TEA block cipher engine: one half-round per clock, 2*ROUNDS cycles per 64-bit block.
// Define TEA_DECRYPT_EN to add the iDecrypt port and the inverse (decrypt) datapath.
module tea_encrypt #(
   parameter int                   WORD_SIZE = 32,
   parameter int                   ROUNDS    = 32,
   parameter logic [WORD_SIZE-1:0] DELTA     = WORD_SIZE'(32'h9E3779B9)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WORD_SIZE-1:0] iKey0,
   input  logic [WORD_SIZE-1:0] iKey1,
   input  logic [WORD_SIZE-1:0] iKey2,
   input  logic [WORD_SIZE-1:0] iKey3,
   input  logic                 iKey_valid,
   input  logic                 iValid,
   input  logic [WORD_SIZE-1:0] iV0,
   input  logic [WORD_SIZE-1:0] iV1,
`ifdef TEA_DECRYPT_EN
   input  logic                 iDecrypt,
`endif
   output logic                 oReady,
   output logic [WORD_SIZE-1:0] oV0,
   output logic [WORD_SIZE-1:0] oV1,
   output logic                 oDone
);

   localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
`ifdef TEA_DECRYPT_EN
   localparam logic [WORD_SIZE-1:0] SUM_DEC = WORD_SIZE'(DELTA * WORD_SIZE'(ROUNDS));
`endif

   typedef enum logic [1:0] {IDLE, ROUND_A, ROUND_B, DONE} state_t;

   state_t               state_r, state_s;
   logic [WORD_SIZE-1:0] k0_r, k1_r, k2_r, k3_r;
   logic [WORD_SIZE-1:0] v0_r, v1_r, sum_r;
   logic [WORD_SIZE-1:0] v0_nx_s, v1_nx_s, sum_nx_s, sum_up_s;
   logic [CW-1:0]        count_r;
   logic                 accept_s, last_s;
   logic                 ready_r, done_r;
   logic [WORD_SIZE-1:0] ov0_r, ov1_r;
`ifdef TEA_DECRYPT_EN
   logic                 dec_r;
`endif

   function automatic logic [WORD_SIZE-1:0] mix(input logic [WORD_SIZE-1:0] v,
                                                input logic [WORD_SIZE-1:0] ka,
                                                input logic [WORD_SIZE-1:0] kb,
                                                input logic [WORD_SIZE-1:0] s);
      mix = ((v << 3'd4) + ka) ^ (v + s) ^ ((v >> 3'd5) + kb);
   endfunction

   assign accept_s = iValid && iKey_valid && (state_r == IDLE);
   assign last_s   = (count_r == CW'(ROUNDS - 1));
   assign oReady   = ready_r;
   assign oDone    = done_r;
   assign oV0      = ov0_r;
   assign oV1      = ov1_r;

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    if (accept_s) state_s = ROUND_A; else state_s = IDLE;
         ROUND_A: state_s = ROUND_B;
         ROUND_B: if (last_s) state_s = DONE; else state_s = ROUND_A;
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Half-round datapath; ROUND_B in encrypt mode sees the v0 written by ROUND_A
   always_comb begin
      v0_nx_s  = v0_r;
      v1_nx_s  = v1_r;
      sum_nx_s = sum_r;
      sum_up_s = sum_r + DELTA;
      case (state_r)
         ROUND_A: begin
`ifdef TEA_DECRYPT_EN
            if (dec_r) begin
               v1_nx_s = v1_r - mix(v0_r, k2_r, k3_r, sum_r);
            end else
`endif
            begin
               sum_nx_s = sum_up_s;
               v0_nx_s  = v0_r + mix(v1_r, k0_r, k1_r, sum_up_s);
            end
         end
         ROUND_B: begin
`ifdef TEA_DECRYPT_EN
            if (dec_r) begin
               v0_nx_s  = v0_r - mix(v1_r, k0_r, k1_r, sum_r);
               sum_nx_s = sum_r - DELTA;
            end else
`endif
            begin
               v1_nx_s = v1_r + mix(v0_r, k2_r, k3_r, sum_r);
            end
         end
         default: begin
            v0_nx_s  = v0_r;
            v1_nx_s  = v1_r;
            sum_nx_s = sum_r;
         end
      endcase
   end

   // State, working registers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         k0_r    <= '0;
         k1_r    <= '0;
         k2_r    <= '0;
         k3_r    <= '0;
         v0_r    <= '0;
         v1_r    <= '0;
         sum_r   <= '0;
         count_r <= '0;
         ready_r <= 1'b1;
         done_r  <= 1'b0;
         ov0_r   <= '0;
         ov1_r   <= '0;
`ifdef TEA_DECRYPT_EN
         dec_r   <= 1'b0;
`endif
      end else begin
         state_r <= state_s;
         ready_r <= (state_s == IDLE);
         done_r  <= (state_r == ROUND_B) && last_s;
         v0_r    <= v0_nx_s;
         v1_r    <= v1_nx_s;
         sum_r   <= sum_nx_s;
         if (accept_s) begin
            k0_r    <= iKey0;
            k1_r    <= iKey1;
            k2_r    <= iKey2;
            k3_r    <= iKey3;
            v0_r    <= iV0;
            v1_r    <= iV1;
            count_r <= '0;
`ifdef TEA_DECRYPT_EN
            dec_r   <= iDecrypt;
            sum_r   <= iDecrypt ? SUM_DEC : '0;
`else
            sum_r   <= '0;
`endif
         end
         if (state_r == ROUND_B) begin
            count_r <= count_r + CW'(1);
            if (last_s) begin
               ov0_r <= v0_nx_s;
               ov1_r <= v1_nx_s;
            end
         end
      end
   end

endmodule
